// File: rtl/gate_truth_checker_pkg.sv
// Package for the gate truth-table checker.
// Contents:
//   state_t       run state (IDLE, COLLECT, DONE_PASS, DONE_FAIL)
//   TRUTH_*       truth tables for the common 2-input gates; bit i = y for input vector i
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        DONE_PASS = 2'd2,
        DONE_FAIL = 2'd3
    } state_t;

    localparam logic [3:0] TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] TRUTH_OR2   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR2  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;
    localparam logic [3:0] TRUTH_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Sample bus carrying one observation of a gate under test.
// Signals:
//   smp_valid  sample present this cycle
//   smp_in     gate input vector (MSB = first input, e.g. {a,b})
//   smp_y      observed gate output
// Modports: master drives the sample, slave (the checker) receives it.
interface gate_truth_checker_if #(
    parameter int unsigned N_IN = 2
);
    logic            smp_valid;
    logic [N_IN-1:0] smp_in;
    logic            smp_y;

    modport master (output smp_valid, output smp_in, output smp_y);
    modport slave  (input  smp_valid, input  smp_in, input  smp_y);
endinterface

// File: rtl/gate_truth_checker_sat_counter.sv
// Saturating up-counter used as the mismatch counter.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   clr    synchronous clear (same effect as reset)
//   inc    count up by one this cycle
//   cnt    current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Response-side checker for a primitive gate: compares each sampled output
// against a parameterised truth table, tracks which input vectors have been
// seen, counts mismatches (saturating) and captures the first failing vector.
// Reports done/pass once every input combination has been sampled.
// Parameters:
//   N_IN   number of gate inputs (1..4)
//   TRUTH  expected output table, bit i = y for input vector i
//   ERR_W  width of the mismatch counter
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   clear          synchronous restart of a check run
//   smp            sample bus (slave): smp_valid, smp_in, smp_y
//   covered        bit i set once vector i has been sampled
//   err_cnt        number of mismatching samples, saturating
//   first_err_vld  a mismatch has been captured
//   first_err_vec  input vector of the first mismatch
//   done           all vectors covered
//   pass           done with no mismatches
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned            N_IN  = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH = TRUTH_OR2,
    parameter int unsigned            ERR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    gate_truth_checker_if.slave     smp,
    output logic [(1<<N_IN)-1:0]    covered,
    output logic [ERR_W-1:0]        err_cnt,
    output logic                    first_err_vld,
    output logic [N_IN-1:0]         first_err_vec,
    output logic                    done,
    output logic                    pass
);

    localparam int unsigned NV = 1 << N_IN;

    state_t          state;
    state_t          state_next;
    logic [NV-1:0]   cov_next;
    logic            mismatch;
    logic            err_any;

    // Sample decode: coverage update and truth-table comparison.
    always_comb begin
        cov_next = covered;
        mismatch = 1'b0;
        if (smp.smp_valid) begin
            cov_next = covered | (NV'(1) << smp.smp_in);
            mismatch = (smp.smp_y != TRUTH[smp.smp_in]);
        end
    end

    // Includes the current sample, so the vector completing coverage is judged too.
    assign err_any = first_err_vld | mismatch;

    always_comb begin
        state_next = state;
        if (smp.smp_valid) begin
            unique case (state)
                IDLE, COLLECT: begin
                    if (&cov_next) begin
                        state_next = err_any ? DONE_FAIL : DONE_PASS;
                    end else begin
                        state_next = COLLECT;
                    end
                end
                DONE_PASS: begin
                    if (mismatch) begin
                        state_next = DONE_FAIL;
                    end
                end
                DONE_FAIL: state_next = DONE_FAIL;
                default:   state_next = IDLE;
            endcase
        end
    end

    // done/pass are flopped from the next state so they change together with covered/err_cnt.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state         <= IDLE;
            covered       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state   <= state_next;
            covered <= cov_next;
            done    <= (state_next == DONE_PASS) || (state_next == DONE_FAIL);
            pass    <= (state_next == DONE_PASS);
            if (mismatch && !first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_vec <= smp.smp_in;
            end
        end
    end

    // clear has priority over inc inside the counter, so a cleared sample is not counted.
    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (mismatch),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    gate_truth_checker_if #(.N_IN(2)) bus_a ();
    gate_truth_checker_if #(.N_IN(2)) bus_b ();

    logic [3:0] cov_a, cov_b;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic       fvld_a, fvld_b, done_a, done_b, pass_a, pass_b;
    logic [1:0] fvec_a, fvec_b;

    gate_truth_checker #(.N_IN(2), .TRUTH(TRUTH_OR2), .ERR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .smp(bus_a.slave),
        .covered(cov_a), .err_cnt(err_a), .first_err_vld(fvld_a),
        .first_err_vec(fvec_a), .done(done_a), .pass(pass_a)
    );

    gate_truth_checker #(.N_IN(2), .TRUTH(TRUTH_OR2), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .smp(bus_b.slave),
        .covered(cov_b), .err_cnt(err_b), .first_err_vld(fvld_b),
        .first_err_vec(fvec_b), .done(done_b), .pass(pass_b)
    );

    typedef struct packed {
        logic [3:0] cov;
        logic [7:0] err;
        logic       fvld;
        logic [1:0] fvec;
        logic       done;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model for DUT A (OR table, 8-bit counter)
    localparam logic [3:0] TT = 4'b1110;
    logic [3:0] m_cov;
    int         m_err;
    logic       m_fvld;
    logic [1:0] m_fvec;
    int         m_st;   // 0 idle, 1 collect, 2 pass, 3 fail

    task automatic model_reset();
        m_cov = '0; m_err = 0; m_fvld = 1'b0; m_fvec = '0; m_st = 0;
    endtask

    task automatic model_sample(input logic v, input logic [1:0] in, input logic y,
                                input logic clr, input logic rst);
        logic mis;
        logic [3:0] nc;
        if (rst || clr) begin
            model_reset();
        end else if (v) begin
            mis = (y != TT[in]);
            nc  = m_cov | (4'b0001 << in);
            if (m_st <= 1)      m_st = (nc == 4'b1111) ? ((m_fvld || mis) ? 3 : 2) : 1;
            else if (m_st == 2) m_st = mis ? 3 : 2;
            m_cov = nc;
            if (mis) begin
                if (m_err < 255) m_err++;
                if (!m_fvld) begin m_fvld = 1'b1; m_fvec = in; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, push model expectation, compare DUT A 1ns after the edge.
    task automatic step(input string tag, input logic on_b, input logic v, input logic [1:0] in,
                        input logic y, input logic clr, input logic rst);
        exp_t e;
        @(negedge clk);
        rst_n = !rst;
        clear = clr;
        bus_a.smp_valid = v && !on_b; bus_a.smp_in = in; bus_a.smp_y = y;
        bus_b.smp_valid = v && on_b;  bus_b.smp_in = in; bus_b.smp_y = y;
        model_sample(v && !on_b, in, y, clr, rst);
        e.cov = m_cov; e.err = 8'(m_err); e.fvld = m_fvld; e.fvec = m_fvec;
        e.done = (m_st >= 2); e.pass = (m_st == 2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cov"},  32'(cov_a),  32'(e.cov));
            chk({tag, "_err"},  32'(err_a),  32'(e.err));
            chk({tag, "_fvld"}, 32'(fvld_a), 32'(e.fvld));
            chk({tag, "_fvec"}, 32'(fvec_a), 32'(e.fvec));
            chk({tag, "_done"}, 32'(done_a), 32'(e.done));
            chk({tag, "_pass"}, 32'(pass_a), 32'(e.pass));
        end
    endtask

    initial begin
        bus_a.smp_valid = 1'b0; bus_a.smp_in = '0; bus_a.smp_y = 1'b0;
        bus_b.smp_valid = 1'b0; bus_b.smp_in = '0; bus_b.smp_y = 1'b0;
        model_reset();

        // Reset state
        step("rst0", 0, 0, 2'b00, 0, 0, 1);
        step("rst1", 0, 0, 2'b00, 0, 0, 1);
        chk("rst_cov_b", 32'(cov_b), 32'd0);
        step("idle", 0, 0, 2'b11, 1, 0, 0);

        // 1: clean OR sweep
        step("t1_00", 0, 1, 2'b00, 0, 0, 0);
        step("t1_01", 0, 1, 2'b01, 1, 0, 0);
        step("t1_10", 0, 1, 2'b10, 1, 0, 0);
        chk("t1_done_early", 32'(done_a), 32'd0);
        step("t1_11", 0, 1, 2'b11, 1, 0, 0);
        chk("t1_pass", 32'(pass_a), 32'd1);
        chk("t1_cov", 32'(cov_a), 32'hF);

        // 2: one wrong sample within a sweep
        step("t2_clr", 0, 0, 2'b00, 0, 1, 0);
        step("t2_00", 0, 1, 2'b00, 0, 0, 0);
        step("t2_01", 0, 1, 2'b01, 1, 0, 0);
        step("t2_10", 0, 1, 2'b10, 0, 0, 0);
        step("t2_11", 0, 1, 2'b11, 1, 0, 0);
        chk("t2_fvec", 32'(fvec_a), 32'h2);
        chk("t2_err", 32'(err_a), 32'd1);
        chk("t2_pass", 32'(pass_a), 32'd0);
        chk("t2_done", 32'(done_a), 32'd1);

        // 3: repeated vectors
        step("t3_clr", 0, 0, 2'b00, 0, 1, 0);
        for (int i = 0; i < 5; i++) step("t3_00", 0, 1, 2'b00, 0, 0, 0);
        step("t3_01", 0, 1, 2'b01, 1, 0, 0);
        chk("t3_cov", 32'(cov_a), 32'h3);
        chk("t3_state", 32'(u_a.state), 32'(COLLECT));

        // 4: DONE_PASS then a late mismatch
        step("t4_10", 0, 1, 2'b10, 1, 0, 0);
        step("t4_11", 0, 1, 2'b11, 1, 0, 0);
        chk("t4_pass_before", 32'(pass_a), 32'd1);
        step("t4_bad", 0, 1, 2'b11, 0, 0, 0);
        chk("t4_state", 32'(u_a.state), 32'(DONE_FAIL));
        chk("t4_err", 32'(err_a), 32'd1);
        chk("t4_done", 32'(done_a), 32'd1);
        step("t4_bad2", 0, 1, 2'b00, 1, 0, 0);
        chk("t4_fvec_held", 32'(fvec_a), 32'h3);
        step("t4_good", 0, 1, 2'b01, 1, 0, 0);

        // 6: clear with a sample, then reset with a sample, mid-run
        step("t6_clr", 0, 1, 2'b10, 0, 1, 0);
        chk("t6_clr_err", 32'(err_a), 32'd0);
        step("t6_a", 0, 1, 2'b01, 0, 0, 0);
        step("t6_b", 0, 1, 2'b00, 0, 0, 0);
        step("t6_rst", 0, 1, 2'b11, 0, 0, 1);
        chk("t6_rst_fvld", 32'(fvld_a), 32'd0);
        step("t6_idle", 0, 0, 2'b11, 0, 0, 0);

        // 5: saturating 2-bit counter on DUT B
        step("t5_clr", 1, 0, 2'b00, 0, 1, 0);
        step("t5_s1", 1, 1, 2'b10, 0, 0, 0);
        chk("t5_fvec1", 32'(fvec_b), 32'h2);
        step("t5_s2", 1, 1, 2'b01, 0, 0, 0);
        step("t5_s3", 1, 1, 2'b11, 0, 0, 0);
        chk("t5_err3", 32'(err_b), 32'd3);
        step("t5_s4", 1, 1, 2'b00, 1, 0, 0);
        step("t5_s5", 1, 1, 2'b10, 0, 0, 0);
        step("t5_s6", 1, 1, 2'b11, 0, 0, 0);
        chk("t5_err_sat", 32'(err_b), 32'd3);
        chk("t5_fvec", 32'(fvec_b), 32'h2);
        chk("t5_fvld", 32'(fvld_b), 32'd1);
        chk("t5_cov", 32'(cov_b), 32'hF);
        chk("t5_done", 32'(done_b), 32'd1);
        chk("t5_pass", 32'(pass_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
